// File: rtl/ame_line_feeder.sv
// Ping-pong 6x6 window buffer feeding the AME Sobel compute stage.
// Rows are loaded into alternating banks, and each full bank is replayed as six lines (rows or columns).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for the read bank to become full
// S_INIT | start pulse to the compute stage, lines follow next cycle
// S_SEND | driving line r_cnt of the read bank
module ame_line_feeder #(
  parameter int LINE_DATA_BITS = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [6*LINE_DATA_BITS-1:0] in_data_i,
  input  logic                        in_dir_i,
  output logic                        comp_init_o,
  output logic [6*LINE_DATA_BITS-1:0] line_data_o,
  input  logic                        comp_done_i,
  output logic                        busy_o
);

  localparam int LW = 6 * LINE_DATA_BITS;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SEND} state_t;

  state_t        r_state;
  logic [LW-1:0] r_mem [2][6];
  logic [1:0]    r_full;
  logic [1:0]    r_dir;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [2:0]    r_wr_row;
  logic [2:0]    r_cnt;
  logic [1:0]    r_outst;

  logic w_accept;
  logic w_last_line;
  logic w_next_full;
  logic w_done_eff;

  assign in_ready_o  = !r_full[r_wr_bank];
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_next_full = r_full[~r_rd_bank];
  assign w_last_line = (r_state == S_SEND) && (r_cnt == 3'd5);
  assign comp_init_o = (r_state == S_INIT) || (w_last_line && w_next_full);
  assign w_done_eff  = comp_done_i && (r_outst != 2'd0);
  assign busy_o      = (|r_full) || (r_state != S_IDLE) || (r_outst != 2'd0) || (r_wr_row != 3'd0);

  // Pixel storage carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wr_row] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_full    <= 2'b00;
      r_dir     <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= 3'd0;
      r_outst   <= 2'd0;
    end else begin
      if (w_accept) begin
        if (r_wr_row == 3'd0) begin
          r_dir[r_wr_bank] <= in_dir_i;
        end
        if (r_wr_row == 3'd5) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_row          <= 3'd0;
        end else begin
          r_wr_row <= r_wr_row + 3'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_state <= S_SEND;
          r_cnt   <= 3'd0;
        end
        S_SEND: begin
          if (r_cnt != 3'd5) begin
            r_cnt <= r_cnt + 3'd1;
          end else begin
            // Partner bank already full: chain straight into its line 0.
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
            r_cnt             <= 3'd0;
            if (!w_next_full) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      case ({comp_init_o, w_done_eff})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   r_outst <= r_outst - 2'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_comb begin
    line_data_o = '0;
    if (r_state == S_SEND) begin
      for (int i = 0; i < 6; i++) begin
        if (r_dir[r_rd_bank]) begin
          line_data_o[i*LINE_DATA_BITS +: LINE_DATA_BITS] =
            r_mem[r_rd_bank][i[2:0]][int'(r_cnt)*LINE_DATA_BITS +: LINE_DATA_BITS];
        end else begin
          line_data_o[i*LINE_DATA_BITS +: LINE_DATA_BITS] =
            r_mem[r_rd_bank][r_cnt][i*LINE_DATA_BITS +: LINE_DATA_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_ame_line_feeder.sv
// Bench for ame_line_feeder: directed timing cases plus randomized windows.
// A window-level scoreboard predicts ready, busy and the line stream.
module tb_ame_line_feeder;

  localparam int W  = 7;
  localparam int LW = 6 * W;
  localparam int WW = 36 * W;

  typedef struct packed {
    logic          dir;
    logic [WW-1:0] pix;
  } win_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [LW-1:0] in_data_i;
  logic          in_dir_i;
  logic          comp_init_o;
  logic [LW-1:0] line_data_o;
  logic          comp_done_i;
  logic          busy_o;

  ame_line_feeder #(.LINE_DATA_BITS(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_dir_i    (in_dir_i),
    .comp_init_o (comp_init_o),
    .line_data_o (line_data_o),
    .comp_done_i (comp_done_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // reference model state
  win_t          win_q[$];
  int            done_q[$];
  int            init_cycles[$];
  logic [WW-1:0] cur_pix;
  logic          cur_dir;
  int            cur_cnt;
  int            line_idx;
  int            outst_m;

  int   cyc;
  int   last_acc_cyc;
  int   stall_cnt;
  int   done_lat;
  logic spurious_done;
  logic chk_en;
  int   n_pass;
  int   n_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [LW-1:0] exp_line(input win_t w, input int k);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < 6; i++) begin
      if (w.dir) l[i*W +: W] = w.pix[(i*6 + k)*W +: W];
      else       l[i*W +: W] = w.pix[(k*6 + i)*W +: W];
    end
    return l;
  endfunction

  function automatic logic [WW-1:0] ramp_win();
    logic [WW-1:0] p;
    p = '0;
    for (int n = 0; n < 36; n++) p[n*W +: W] = 7'(n);
    return p;
  endfunction

  function automatic logic [WW-1:0] rnd_win();
    logic [WW-1:0] p;
    logic [63:0]   x;
    p = '0;
    for (int r = 0; r < 6; r++) begin
      x = {$urandom(), $urandom()};
      p[r*LW +: LW] = x[LW-1:0];
    end
    return p;
  endfunction

  function automatic int init_at(input int n);
    return (init_cycles.size() > n) ? init_cycles[n] : -1;
  endfunction

  task automatic model_reset();
    win_q.delete();
    done_q.delete();
    cur_cnt  = 0;
    cur_pix  = '0;
    cur_dir  = 1'b0;
    line_idx = -1;
    outst_m  = 0;
  endtask

  // One clock cycle: drive done, check outputs, advance the model past the edge.
  task automatic tick();
    logic          exp_ready, exp_busy, acc, init_seen, done_now, start_next, dec;
    logic [LW-1:0] d_data;
    logic          d_dir;
    int            c0, nd, tmp, old_outst;
    win_t          w;
    c0       = cyc;
    done_now = spurious_done;
    if (done_q.size() > 0 && done_q[0] == c0) begin
      done_now = 1'b1;
      tmp = done_q.pop_front();
    end
    comp_done_i = done_now;
    #1;
    init_seen  = comp_init_o;
    start_next = comp_init_o && (line_idx == -1 || line_idx == 5) &&
                 (win_q.size() > ((line_idx >= 0) ? 1 : 0));
    if (chk_en) begin
      exp_ready = (win_q.size() < 2);
      exp_busy  = (win_q.size() != 0) || (cur_cnt != 0) || (outst_m != 0);
      chk("in_ready", 64'(in_ready_o), 64'(exp_ready));
      chk("busy", 64'(busy_o), 64'(exp_busy));
      if (line_idx >= 0) chk("line", 64'(line_data_o), 64'(exp_line(win_q[0], line_idx)));
      else               chk("idle_line", 64'(line_data_o), 64'd0);
      if (comp_init_o) chk("init_ok", 64'(start_next), 64'd1);
    end
    if (in_valid_i && !in_ready_o) stall_cnt++;
    acc    = in_valid_i && !rst_i && (win_q.size() < 2);
    d_data = in_data_i;
    d_dir  = in_dir_i;
    if (acc) last_acc_cyc = c0;
    if (init_seen) init_cycles.push_back(c0);
    @(posedge clk_i);
    #1;
    cyc++;
    if (rst_i) begin
      model_reset();
    end else begin
      if (acc) begin
        if (cur_cnt == 0) cur_dir = d_dir;
        cur_pix[cur_cnt*LW +: LW] = d_data;
        cur_cnt++;
        if (cur_cnt == 6) begin
          w.dir = cur_dir;
          w.pix = cur_pix;
          win_q.push_back(w);
          cur_cnt = 0;
        end
      end
      if (line_idx >= 0) begin
        line_idx++;
        if (line_idx == 6) begin
          w = win_q.pop_front();
          line_idx = -1;
        end
      end
      if (start_next) line_idx = 0;
      old_outst = outst_m;
      dec = done_now && (old_outst > 0);
      if (init_seen) begin
        nd = c0 + done_lat;
        if (done_q.size() > 0 && nd <= done_q[$]) nd = done_q[$] + 1;
        done_q.push_back(nd);
      end
      outst_m = old_outst + (init_seen ? 1 : 0) - (dec ? 1 : 0);
    end
  endtask

  task automatic send_window(input logic [WW-1:0] pix, input logic dir, input int gap_pct,
                             input int nrows);
    int            r;
    int            guard;
    logic [63:0]   x;
    r = 0;
    guard = 0;
    while (r < nrows && guard < 500) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        x = {$urandom(), $urandom()};
        in_valid_i = 1'b0;
        in_data_i  = x[LW-1:0];
        in_dir_i   = 1'($urandom_range(1, 0));
      end else begin
        in_valid_i = 1'b1;
        in_data_i  = pix[r*LW +: LW];
        in_dir_i   = (r == 0) ? dir : 1'($urandom_range(1, 0));
        if (win_q.size() < 2) r++;
      end
      tick();
      guard++;
    end
    if (r < nrows) chk("send_timeout", 64'(r), 64'(nrows));
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid_i = 1'b0;
    while ((win_q.size() != 0 || line_idx >= 0 || outst_m != 0) && g < 300) begin
      tick();
      g++;
    end
    tick();
    chk("drain", 64'(win_q.size() + outst_m), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1;
    n_pass = 0; n_chk = 0; cyc = 0; stall_cnt = 0; last_acc_cyc = 0;
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_dir_i = 1'b0;
    comp_done_i = 1'b0; spurious_done = 1'b0; done_lat = 7; chk_en = 1'b0;
    model_reset();
    tick();
    tick();
    rst_i  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_init", 64'(comp_init_o), 64'd0);
    chk("rst_line", 64'(line_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);

    // single ramp window, rows then columns
    for (int d = 0; d < 2; d++) begin
      init_cycles.delete();
      send_window(ramp_win(), 1'(d), 0, 6);
      t = last_acc_cyc;
      drain();
      chk("single_init_cnt", 64'(init_cycles.size()), 64'd1);
      chk("single_init_lat", 64'(init_at(0)), 64'(t + 2));
    end

    // three windows with valid held high
    init_cycles.delete();
    stall_cnt = 0;
    send_window(rnd_win(), 1'($urandom_range(1, 0)), 0, 6);
    t1 = last_acc_cyc;
    send_window(rnd_win(), 1'($urandom_range(1, 0)), 0, 6);
    send_window(rnd_win(), 1'($urandom_range(1, 0)), 0, 6);
    drain();
    chk("b2b_init_cnt", 64'(init_cycles.size()), 64'd3);
    chk("b2b_init0", 64'(init_at(0)), 64'(t1 + 2));
    chk("b2b_init1", 64'(init_at(1)), 64'(init_at(0) + 6));
    chk("b2b_init2", 64'(init_at(2)), 64'(init_at(1) + 8));
    chk("b2b_stalls", 64'(stall_cnt), 64'd2);

    // reset during line 3 with three rows of the next window loaded
    send_window(rnd_win(), 1'b0, 0, 6);
    send_window(rnd_win(), 1'b1, 0, 3);
    t = 0;
    while (line_idx != 3 && t < 50) begin
      tick();
      t++;
    end
    chk("mid_reach_line3", 64'(line_idx), 64'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
    chk("mid_rst_init", 64'(comp_init_o), 64'd0);
    chk("mid_rst_line", 64'(line_data_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    init_cycles.delete();
    send_window(rnd_win(), 1'b1, 0, 6);
    t = last_acc_cyc;
    drain();
    chk("post_rst_init_lat", 64'(init_at(0)), 64'(t + 2));

    // spurious done while idle
    spurious_done = 1'b1;
    tick();
    spurious_done = 1'b0;
    #1;
    chk("spur_busy", 64'(busy_o), 64'd0);
    init_cycles.delete();
    send_window(rnd_win(), 1'b0, 0, 6);
    t = last_acc_cyc;
    drain();
    chk("spur_init_lat", 64'(init_at(0)), 64'(t + 2));

    // randomized windows, gaps and compute latency
    for (int ph = 0; ph < 3; ph++) begin
      done_lat = $urandom_range(10, 1);
      for (int n = 0; n < 12; n++) begin
        send_window(rnd_win(), 1'($urandom_range(1, 0)), $urandom_range(50, 0), 6);
        for (int g = $urandom_range(8, 0); g > 0; g--) tick();
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
